// File: rtl/gpu_krypton_pkg.sv
// Shared types for the Krypton GPU host register/command bus.
//   host_op_t     : request opcode carried on the CPU-side queue
//   host_state_t  : submitter FSM states (also exported on the debug port)
//   gpu_command_t : 160-bit command packet layout written to the GPU command register
//   host_req_t    : one buffered request (opcode, register offset, payload)
//   pack_cmd()    : builds a command packet with the unused bits [31:4] cleared
package gpu_krypton_pkg;

  localparam logic [11:0] CMD_ADDR_DEFAULT = 12'h100;
  localparam int          REQ_DATA_W       = 160;

  typedef enum logic [1:0] {
    REG_WR = 2'd0,
    REG_RD = 2'd1,
    CMD    = 2'd2,
    RSVD   = 2'd3
  } host_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RECOVER = 2'd2
  } host_state_t;

  typedef struct packed {
    logic [31:0] p4;
    logic [31:0] p3;
    logic [31:0] p2;
    logic [31:0] p1;
    logic [27:0] pad;
    logic [3:0]  cmd;
  } gpu_command_t;

  typedef struct packed {
    host_op_t              op;
    logic [11:0]           addr;
    logic [REQ_DATA_W-1:0] data;
  } host_req_t;

  function automatic logic [REQ_DATA_W-1:0] pack_cmd(
    input logic [3:0]  cmd,
    input logic [31:0] p1,
    input logic [31:0] p2,
    input logic [31:0] p3,
    input logic [31:0] p4
  );
    gpu_command_t c;
    c.cmd = cmd;
    c.pad = '0;
    c.p1  = p1;
    c.p2  = p2;
    c.p3  = p3;
    c.p4  = p4;
    return c;
  endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Single-clock FIFO with registered pointers and a level counter.
// Ports:
//   clk_core, rst_n : clock, asynchronous active-low reset
//   push, wdata     : write strobe and data (ignored when full)
//   pop             : read strobe (ignored when empty); head advances next cycle
//   rdata           : current head entry (combinational read)
//   full, empty     : status flags derived from level
//   level           : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module gpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_core,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rd_ptr];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_core) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_host_cmd_submitter.sv
// Host-side initiator for the Krypton GPU host register/command bus.
// Buffers CPU requests (register write, register read, command packet) in a FIFO
// and issues each one as a single req/ack transaction on the host bus.
// Ports:
//   clk_core, rst_n        : core clock, asynchronous active-low reset
//   req_valid/req_ready    : CPU request handshake; req_op/req_addr/req_data payload
//   rsp_valid/rsp_data/rsp_error : one-cycle response (read data or error)
//   host_req/host_we/host_addr/host_wdata : host bus request, held until ack/timeout
//   host_rdata/host_ack    : host bus read data and one-cycle acknowledge
//   busy                   : requests buffered or a transaction in progress
//   cmd_sent               : wrapping count of acknowledged command packets
//   err_sticky/err_clr     : sticky error flag (set wins over clear)
//   dbg_state              : current FSM state (host_state_t encoding)
//
// Handshake: a request is accepted on every rising clk_core edge where
// req_valid && req_ready; req_ready is !full and does not depend on req_valid.
// The host side accepts exactly one outstanding transaction: host_req stays
// high with stable addr/we/wdata until host_ack is sampled 1 or the timeout expires.
module gpu_host_cmd_submitter
  import gpu_krypton_pkg::*;
#(
  parameter int          DATA_W         = 512,  // must be >= 160
  parameter int          FIFO_DEPTH     = 16,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [11:0] CMD_ADDR       = CMD_ADDR_DEFAULT
) (
  input  logic              clk_core,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [11:0]       req_addr,
  input  logic [159:0]      req_data,
  output logic              rsp_valid,
  output logic [63:0]       rsp_data,
  output logic              rsp_error,
  output logic              host_req,
  output logic              host_we,
  output logic [31:0]       host_addr,
  output logic [DATA_W-1:0] host_wdata,
  input  logic [DATA_W-1:0] host_rdata,
  input  logic              host_ack,
  output logic              busy,
  output logic [31:0]       cmd_sent,
  output logic              err_sticky,
  input  logic              err_clr,
  output logic [1:0]        dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  host_state_t          state;
  host_state_t          state_nxt;
  host_req_t            req_in;
  host_req_t            head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LW-1:0]        fifo_level;
  logic                 fifo_pop;
  logic                 launch;
  logic                 drop_rsvd;
  logic                 ack_done;
  logic                 timed_out;
  logic [TW-1:0]        timer;
  host_op_t             cur_op;
  logic [REQ_DATA_W-1:0] launch_payload;
  logic [31:0]          launch_addr;
  logic                 unused_rdata;

  assign unused_rdata = ^host_rdata[DATA_W-1:64];

  assign req_in.op   = host_op_t'(req_op);
  assign req_in.addr = req_addr;
  assign req_in.data = req_data;

  assign req_ready = !fifo_full;

  gpu_sync_fifo #(
    .WIDTH ($bits(host_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_core (clk_core),
    .rst_n    (rst_n),
    .push     (req_valid && !fifo_full),
    .wdata    (req_in),
    .pop      (fifo_pop),
    .rdata    (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign busy      = (fifo_level != '0) || (state != IDLE);
  assign dbg_state = state;

  // Commands always go to the GPU command register with the unused
  // low-word bits cleared; register ops pass the payload through.
  always_comb begin
    launch_payload = head.data;
    launch_addr    = {20'h0, head.addr};
    if (head.op == CMD) begin
      launch_payload = pack_cmd(head.data[3:0], head.data[63:32], head.data[95:64],
                                head.data[127:96], head.data[159:128]);
      launch_addr    = {20'h0, CMD_ADDR};
    end
  end

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RECOVER behaves like IDLE once host_ack is low: the GPU re-acks a held
  // request, so a new request must not rise while ack is still high.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    launch    = 1'b0;
    drop_rsvd = 1'b0;
    ack_done  = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE, RECOVER: begin
        if (state == RECOVER && host_ack) begin
          state_nxt = RECOVER;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.op == RSVD) begin
            drop_rsvd = 1'b1;
            state_nxt = IDLE;
          end else begin
            launch    = 1'b1;
            state_nxt = ISSUE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (host_ack) begin
          ack_done  = 1'b1;
          state_nxt = RECOVER;
        end else if (timer == TIMER_LAST) begin
          timed_out = 1'b1;
          state_nxt = RECOVER;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      host_req   <= 1'b0;
      host_we    <= 1'b0;
      host_addr  <= '0;
      host_wdata <= '0;
      cur_op     <= REG_WR;
      timer      <= '0;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_data   <= '0;
      cmd_sent   <= '0;
      err_sticky <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;

      if (launch) begin
        host_req   <= 1'b1;
        host_we    <= (head.op != REG_RD);
        host_addr  <= launch_addr;
        host_wdata <= DATA_W'(launch_payload);
        cur_op     <= head.op;
        timer      <= '0;
      end else if (state == ISSUE && !ack_done && !timed_out) begin
        timer <= timer + TW'(1);
      end

      if (ack_done) begin
        host_req <= 1'b0;
        if (cur_op == REG_RD) begin
          rsp_valid <= 1'b1;
          rsp_data  <= host_rdata[63:0];
        end
        if (cur_op == CMD) begin
          cmd_sent <= cmd_sent + 32'd1;
        end
      end

      if (timed_out) begin
        host_req  <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_error <= 1'b1;
        rsp_data  <= '0;
      end

      if (drop_rsvd) begin
        rsp_valid <= 1'b1;
        rsp_error <= 1'b1;
        rsp_data  <= '0;
      end

      if (timed_out || drop_rsvd) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpu_host_cmd_submitter.sv
module tb_gpu_host_cmd_submitter;

  localparam int DATA_W  = 512;
  localparam int TIMEOUT = 8;
  localparam int BW      = 8 + 1 + 32 + DATA_W;

  logic              clk_core;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [11:0]       req_addr;
  logic [159:0]      req_data;
  logic              rsp_valid;
  logic [63:0]       rsp_data;
  logic              rsp_error;
  logic              host_req;
  logic              host_we;
  logic [31:0]       host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;
  logic              busy;
  logic [31:0]       cmd_sent;
  logic              err_sticky;
  logic              err_clr;
  logic [1:0]        dbg_state;

  gpu_host_cmd_submitter #(
    .DATA_W         (DATA_W),
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CMD_ADDR       (12'h100)
  ) dut (
    .clk_core   (clk_core),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_error  (rsp_error),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .busy       (busy),
    .cmd_sent   (cmd_sent),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_core = 1'b0;
    forever #5 clk_core = ~clk_core;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp;
  int n_bad;
  logic [64:0]   exp_rsp_q[$];   // {error, data}
  logic [BW-1:0] exp_bus_q[$];   // {hold_cycles, we, addr, wdata}
  int            exp_cmd_cnt;
  bit            exp_err;
  bit            phase3;
  int            p3_pushed;
  int            p3_launched;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // GPU register model used by the responder: value returned for a read.
  function automatic logic [63:0] rd_value(input logic [11:0] a);
    if (a == 12'h000) return 64'h0000_0000_0001_0300;
    return {20'hABCDE, a, 20'h13579, a};
  endfunction

  // Responder regions by register offset: 0xE.. never acks, 0xD.. never acks
  // during the request but acks once right after req falls; anything else
  // acks one cycle after seeing req.
  function automatic bit no_ack_region(input logic [11:0] a);
    return (a[11:8] == 4'hE) || (a[11:8] == 4'hD);
  endfunction

  // Reference model: what the bus and response channel must show for one request.
  task automatic model_submit(input logic [1:0] op, input logic [11:0] addr,
                              input logic [159:0] data);
    logic [159:0] payload;
    logic [31:0]  a;
    logic [7:0]   hold;
    bit           dead;
    if (op == 2'd3) begin
      exp_rsp_q.push_back({1'b1, 64'h0});
      exp_err = 1'b1;
      return;
    end
    payload = data;
    a       = {20'h0, addr};
    if (op == 2'd2) begin
      payload[31:4] = '0;
      a = 32'h0000_0100;
    end
    dead = no_ack_region(a[11:0]);
    hold = dead ? 8'(TIMEOUT) : 8'd2;
    exp_bus_q.push_back({hold, (op != 2'd1), a, DATA_W'(payload)});
    if (dead) begin
      exp_rsp_q.push_back({1'b1, 64'h0});
      exp_err = 1'b1;
    end else if (op == 2'd1) begin
      exp_rsp_q.push_back({1'b0, rd_value(addr)});
    end
    if (op == 2'd2) exp_cmd_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic [1:0] op, input logic [11:0] addr,
                          input logic [159:0] data);
    int guard;
    guard = 0;
    @(negedge clk_core);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    while (!req_ready && guard < 300) begin
      @(negedge clk_core);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_wait: req_ready stayed 0 for %0d cycles, expected 1", guard);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk_core);
    model_submit(op, addr, data);
    if (phase3) p3_pushed++;
  endtask

  task automatic go_idle();
    @(negedge clk_core);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_bus_q.size() != 0 || exp_rsp_q.size() != 0 || busy) && guard < 3000) begin
      @(negedge clk_core);
      guard++;
    end
    if (guard >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: still busy after %0d cycles (bus_q=%0d rsp_q=%0d), expected idle",
               guard, exp_bus_q.size(), exp_rsp_q.size());
    end
    repeat (3) @(negedge clk_core);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk_core);
    err_clr = 1'b1;
    @(negedge clk_core);
    err_clr = 1'b0;
    exp_err = 1'b0;
  endtask

  function automatic logic [159:0] rand160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- GPU responder ----------------
  int          r_cnt;
  bit          r_prev;
  logic [11:0] r_addr;

  initial begin
    host_ack   = 1'b0;
    host_rdata = '0;
    r_cnt      = 0;
    r_prev     = 1'b0;
    r_addr     = '0;
    forever begin
      @(negedge clk_core);
      if (host_req) begin
        r_cnt++;
        r_addr = host_addr[11:0];
      end else begin
        r_cnt = 0;
      end
      host_ack   = 1'b0;
      host_rdata = {16{$urandom()}};
      if (host_req && r_cnt == 2 && !no_ack_region(r_addr)) begin
        host_ack          = 1'b1;
        host_rdata[63:0]  = rd_value(r_addr);
      end else if (!host_req && r_prev && r_addr[11:8] == 4'hD) begin
        host_ack = 1'b1;
      end
      r_prev = host_req;
    end
  end

  // ---------------- monitor ----------------
  bit            m_prev_req;
  int            m_hold;
  int            m_hold_exp;
  int            m_cyc;
  int            m_last_rise;
  logic [BW-1:0] m_e;
  logic [64:0]   m_r;

  initial begin
    m_prev_req  = 1'b0;
    m_hold      = 0;
    m_hold_exp  = 0;
    m_cyc       = 0;
    m_last_rise = 0;
    forever begin
      @(posedge clk_core);
      #1;
      m_cyc++;
      if (!rst_n) begin
        m_prev_req = 1'b0;
        m_hold     = 0;
        continue;
      end
      if (host_req && !m_prev_req) begin
        check("ack_low_at_issue", 64'(host_ack), 64'd0);
        n_cmp++;
        if (exp_bus_q.size() == 0) begin
          n_bad++;
          $display("FAIL bus_txn: got unexpected request addr=0x%0h, expected none", host_addr);
          m_hold_exp = -1;
        end else begin
          m_e = exp_bus_q.pop_front();
          m_hold_exp = int'(m_e[BW-1 -: 8]);
          if ({host_we, host_addr, host_wdata} !== m_e[BW-9:0]) begin
            n_bad++;
            $display("FAIL bus_txn: got we=%0d addr=0x%0h wdata=0x%0h expected we=%0d addr=0x%0h wdata=0x%0h",
                     host_we, host_addr, host_wdata, m_e[BW-9], m_e[BW-10 -: 32], m_e[DATA_W-1:0]);
          end
        end
        if (phase3 && p3_launched > 0) begin
          check("issue_spacing", 64'(m_cyc - m_last_rise), 64'd3);
        end
        m_last_rise = m_cyc;
        if (phase3) p3_launched++;
        m_hold = 0;
      end
      if (host_req) m_hold++;
      if (!host_req && m_prev_req) begin
        check("req_hold_cycles", 64'(m_hold), 64'(m_hold_exp));
      end
      if (rsp_valid) begin
        n_cmp++;
        if (exp_rsp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rsp: got unexpected err=%0d data=0x%0h, expected no response",
                   rsp_error, rsp_data);
        end else begin
          m_r = exp_rsp_q.pop_front();
          if ({rsp_error, rsp_data} !== m_r) begin
            n_bad++;
            $display("FAIL rsp: got err=%0d data=0x%0h expected err=%0d data=0x%0h",
                     rsp_error, rsp_data, m_r[64], m_r[63:0]);
          end
        end
      end
      if (phase3) begin
        check("req_ready_vs_level", 64'(req_ready), 64'((p3_pushed - p3_launched) != 16));
      end
      m_prev_req = host_req;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  op;
    logic [11:0] addr;
    int          guard;
    n_cmp       = 0;
    n_bad       = 0;
    exp_cmd_cnt = 0;
    exp_err     = 1'b0;
    phase3      = 1'b0;
    p3_pushed   = 0;
    p3_launched = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_op      = '0;
    req_addr    = '0;
    req_data    = '0;
    err_clr     = 1'b0;

    repeat (3) @(negedge clk_core);
    check("reset_host_req",   64'(host_req),   64'd0);
    check("reset_host_addr",  64'(host_addr),  64'd0);
    check("reset_rsp_valid",  64'(rsp_valid),  64'd0);
    check("reset_busy",       64'(busy),       64'd0);
    check("reset_cmd_sent",   64'(cmd_sent),   64'd0);
    check("reset_err_sticky", 64'(err_sticky), 64'd0);
    check("reset_req_ready",  64'(req_ready),  64'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_core);

    // Single command packet.
    push_req(2'd2, 12'h000, {32'h44, 32'h33, 32'h22, 32'h11, 32'h0000_0004});
    go_idle();
    wait_drain();
    check("cmd_sent_single", 64'(cmd_sent), 64'(exp_cmd_cnt));

    // Register read at offset 0.
    push_req(2'd1, 12'h000, rand160());
    go_idle();
    wait_drain();
    check("err_after_read", 64'(err_sticky), 64'(exp_err));

    // Back-to-back commands: FIFO fills, issues every 3 cycles.
    phase3      = 1'b1;
    p3_pushed   = 0;
    p3_launched = 0;
    for (int i = 0; i < 30; i++) begin
      push_req(2'd2, 12'($urandom()), rand160());
    end
    go_idle();
    wait_drain();
    phase3 = 1'b0;
    check("cmd_sent_burst", 64'(cmd_sent), 64'(exp_cmd_cnt));

    // Timeout, then the next queued op still goes out; err_clr clears the flag.
    push_req(2'd1, 12'hE40, rand160());
    push_req(2'd0, 12'h010, rand160());
    go_idle();
    wait_drain();
    check("err_after_timeout", 64'(err_sticky), 64'(exp_err));
    pulse_err_clr();
    @(negedge clk_core);
    check("err_after_clr", 64'(err_sticky), 64'(exp_err));

    // Late ack while recovering, with a write waiting behind it.
    push_req(2'd1, 12'hD08, rand160());
    push_req(2'd0, 12'h020, rand160());
    go_idle();
    wait_drain();
    check("err_after_late_ack", 64'(err_sticky), 64'(exp_err));
    pulse_err_clr();

    // Randomized traffic including reserved ops and non-responding offsets.
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = {4'hE, 8'($urandom())};
      else                           addr = 12'($urandom_range(0, 12'hCFF));
      push_req(op, addr, rand160());
      if ($urandom_range(0, 3) == 0) begin
        go_idle();
        repeat ($urandom_range(1, 6)) @(negedge clk_core);
      end
    end
    go_idle();
    wait_drain();
    check("cmd_sent_random", 64'(cmd_sent), 64'(exp_cmd_cnt));
    check("err_random",      64'(err_sticky), 64'(exp_err));

    // Reset while a request is held and more are queued.
    push_req(2'd1, 12'hE00, rand160());
    push_req(2'd2, 12'h000, rand160());
    push_req(2'd2, 12'h000, rand160());
    go_idle();
    guard = 0;
    while (!host_req && guard < 50) begin
      @(negedge clk_core);
      guard++;
    end
    check("req_before_reset", 64'(host_req), 64'd1);
    repeat (2) @(negedge clk_core);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_host_req", 64'(host_req),   64'd0);
    check("async_reset_busy",     64'(busy),       64'd0);
    check("async_reset_cmd_sent", 64'(cmd_sent),   64'd0);
    check("async_reset_ready",    64'(req_ready),  64'd1);
    check("async_reset_err",      64'(err_sticky), 64'd0);
    exp_bus_q.delete();
    exp_rsp_q.delete();
    exp_cmd_cnt = 0;
    exp_err     = 1'b0;
    repeat (2) @(negedge clk_core);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_core);
    check("post_reset_idle_req", 64'(host_req), 64'd0);

    for (int i = 0; i < 8; i++) begin
      push_req(2'($urandom_range(0, 2)), 12'($urandom_range(0, 12'hCFF)), rand160());
    end
    go_idle();
    wait_drain();
    check("cmd_sent_after_reset", 64'(cmd_sent), 64'(exp_cmd_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
